// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - REG_FILE writeback arbiter with RAW scoreboard; optional forwarding via RF_WB_FWD_EN
module rf_wb_arbiter #(
   parameter int CNT_W      = 2,
   parameter int START_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        iss_valid,
   input  logic [4:0]  iss_rd,
   output logic        iss_ready,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [4:0]  req0_addr,
   input  logic [31:0] req0_data,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [4:0]  req1_addr,
   input  logic [31:0] req1_data,
   input  logic [4:0]  rs1_addr,
   input  logic [4:0]  rs2_addr,
   output logic        rs1_busy,
   output logic        rs2_busy,
   output logic        rf_wen,
   output logic [4:0]  wr_addr,
   output logic [31:0] wd
`ifdef RF_WB_FWD_EN
   ,
   output logic        fwd1_hit,
   output logic        fwd2_hit,
   output logic [31:0] fwd1_data,
   output logic [31:0] fwd2_data
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             rr_q, rr_d;
   logic             rf_wen_q, rf_wen_d;
   logic [4:0]       wr_addr_q, wr_addr_d;
   logic [31:0]      wd_q, wd_d;
   logic [CNT_W-1:0] cnt_q [32];
   logic [CNT_W-1:0] cnt_d [32];

   logic             gnt0, gnt1;
   logic [4:0]       gnt_addr;
   logic [31:0]      gnt_data;
   logic             inc_en, dec_en;
   logic [4:0]       dec_addr;
   logic             underflow;

   // Round-robin grant and next write-port contents; the pointer only moves on contention
   always_comb begin
      gnt0      = req0_valid && (!req1_valid || !rr_q);
      gnt1      = req1_valid && (!req0_valid || rr_q);
      rr_d      = rr_q;
      if (req0_valid && req1_valid) begin
         rr_d = ~rr_q;
      end
      gnt_addr  = gnt1 ? req1_addr : req0_addr;
      gnt_data  = gnt1 ? req1_data : req0_data;
      rf_wen_d  = (gnt0 || gnt1) && (gnt_addr != 5'd0);
      wr_addr_d = wr_addr_q;
      wd_d      = wd_q;
      if (rf_wen_d) begin
         wr_addr_d = gnt_addr;
         wd_d      = gnt_data;
      end
   end

   // Outstanding-write counters: issue increments, commit decrements, both together cancel
   always_comb begin
      iss_ready = (iss_rd == 5'd0) || (cnt_q[iss_rd] != CNT_MAX);
      inc_en    = iss_valid && iss_ready && (iss_rd != 5'd0);
`ifdef RF_WB_FWD_EN
      // With forwarding, decode can take the value off the bypass, so commit at acceptance
      dec_en    = rf_wen_d;
      dec_addr  = gnt_addr;
`else
      // Without forwarding, commit only once REG_FILE has actually written
      dec_en    = rf_wen_q;
      dec_addr  = wr_addr_q;
`endif
      underflow = dec_en && !(inc_en && (iss_rd == dec_addr)) && (cnt_q[dec_addr] == '0);
      cnt_d[0]  = '0;
      for (int r = 1; r < 32; r++) begin
         cnt_d[r] = cnt_q[r];
         if (inc_en && (iss_rd == 5'(r)) && !(dec_en && (dec_addr == 5'(r)))) begin
            cnt_d[r] = cnt_q[r] + CNT_ONE;
         end else if (dec_en && (dec_addr == 5'(r)) && !(inc_en && (iss_rd == 5'(r)))) begin
            if (cnt_q[r] != '0) begin
               cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
         end
      end
   end

   // State registers; reset drops any write in flight and clears the scoreboard
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q      <= (START_PRIO != 0);
         rf_wen_q  <= 1'b0;
         wr_addr_q <= '0;
         wd_q      <= '0;
         cnt_q     <= '{default: '0};
      end else begin
         rr_q      <= rr_d;
         rf_wen_q  <= rf_wen_d;
         wr_addr_q <= wr_addr_d;
         wd_q      <= wd_d;
         cnt_q     <= cnt_d;
      end
   end

   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !underflow);

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign rf_wen     = rf_wen_q;
   assign wr_addr    = wr_addr_q;
   assign wd         = wd_q;
   assign rs1_busy   = (rs1_addr != 5'd0) && (cnt_q[rs1_addr] != '0);
   assign rs2_busy   = (rs2_addr != 5'd0) && (cnt_q[rs2_addr] != '0);

`ifdef RF_WB_FWD_EN
   assign fwd1_hit   = rf_wen_q && (wr_addr_q == rs1_addr) && (rs1_addr != 5'd0);
   assign fwd2_hit   = rf_wen_q && (wr_addr_q == rs2_addr) && (rs2_addr != 5'd0);
   assign fwd1_data  = wd_q;
   assign fwd2_data  = wd_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter; honours RF_WB_FWD_EN
module tb_rf_wb_arbiter;

   localparam int SAT = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid, iss_ready;
   logic [4:0]  iss_rd;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [4:0]  req0_addr, req1_addr, rs1_addr, rs2_addr, wr_addr;
   logic [31:0] req0_data, req1_data, wd;
   logic        rs1_busy, rs2_busy, rf_wen;
`ifdef RF_WB_FWD_EN
   logic        fwd1_hit, fwd2_hit;
   logic [31:0] fwd1_data, fwd2_data;
`endif

   rf_wb_arbiter #(.CNT_W(2), .START_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .rf_wen(rf_wen), .wr_addr(wr_addr), .wd(wd)
`ifdef RF_WB_FWD_EN
      ,
      .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   int  vectors = 0;
   int  miscompares = 0;

   // reference model: outstanding writes per register, reserved issues, arbitration pointer
   int  cnt_m [32];
   int  avail [32];
   bit  prio_m;
   bit  pend_v;
   logic [4:0] pend_a;
   bit  cur_v;
   wr_t cur_w;
   wr_t q0[$], q1[$], exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         cnt_m[i] = 0;
         avail[i] = 0;
      end
      prio_m = 1'b0;
      pend_v = 1'b0;
      cur_v  = 1'b0;
      q0.delete();
      q1.delete();
      exp_q.delete();
   endtask

   // Directed request to a register that was issued earlier
   task automatic push_req(input int who, input logic [4:0] a, input logic [31:0] d);
      wr_t w;
      w.a = a;
      w.d = d;
      if (a != 5'd0) avail[a]--;
      if (who == 0) q0.push_back(w);
      else q1.push_back(w);
   endtask

   // One clock cycle: drive at negedge, check combinational outputs, advance model at posedge
   task automatic step(input bit iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2);
      bit  v0, v1, g0, g1, ir_e, hit;
      wr_t w;
      v0 = (q0.size() != 0);
      v1 = (q1.size() != 0);
      req0_valid = v0;
      req0_addr  = v0 ? q0[0].a : 5'($urandom);
      req0_data  = v0 ? q0[0].d : $urandom;
      req1_valid = v1;
      req1_addr  = v1 ? q1[0].a : 5'($urandom);
      req1_data  = v1 ? q1[0].d : $urandom;
      iss_valid  = iv;
      iss_rd     = ird;
      rs1_addr   = r1;
      rs2_addr   = r2;
      #1;
      g0   = v0 && (!v1 || !prio_m);
      g1   = v1 && (!v0 || prio_m);
      ir_e = (ird == 5'd0) || (cnt_m[ird] < SAT);
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
      chk("iss_ready", {31'd0, iss_ready}, {31'd0, ir_e});
      chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, (r1 != 5'd0) && (cnt_m[r1] != 0)});
      chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, (r2 != 5'd0) && (cnt_m[r2] != 0)});
`ifdef RF_WB_FWD_EN
      hit = cur_v && (cur_w.a == r1) && (r1 != 5'd0);
      chk("fwd1_hit", {31'd0, fwd1_hit}, {31'd0, hit});
      if (hit) chk("fwd1_data", fwd1_data, cur_w.d);
      hit = cur_v && (cur_w.a == r2) && (r2 != 5'd0);
      chk("fwd2_hit", {31'd0, fwd2_hit}, {31'd0, hit});
      if (hit) chk("fwd2_data", fwd2_data, cur_w.d);
`else
      hit = 1'b0;
`endif
      @(posedge clk);
      if (pend_v) cnt_m[pend_a]--;
      pend_v = 1'b0;
      if (iv && ir_e && (ird != 5'd0)) begin
         cnt_m[ird]++;
         avail[ird]++;
      end
      cur_v = 1'b0;
      if (g0 || g1) begin
         w = g0 ? q0.pop_front() : q1.pop_front();
         if (v0 && v1) prio_m = !prio_m;
         if (w.a != 5'd0) begin
            exp_q.push_back(w);
            cur_v = 1'b1;
            cur_w = w;
`ifdef RF_WB_FWD_EN
            cnt_m[w.a]--;
`else
            pend_v = 1'b1;
            pend_a = w.a;
`endif
         end
      end
      @(negedge clk);
   endtask

   // Random cycle: maybe queue new requests against issued registers, random issue and reads
   task automatic rand_step();
      int  s;
      wr_t w;
      for (int who = 0; who < 2; who++) begin
         if ((who == 0 ? q0.size() : q1.size()) == 0 && $urandom_range(0, 3) != 0) begin
            w.a = 5'd0;
            w.d = $urandom;
            if ($urandom_range(0, 7) != 0) begin
               s = $urandom_range(0, 31);
               for (int k = 0; k < 32; k++) begin
                  if (w.a == 5'd0 && ((s + k) % 32) != 0 && avail[(s + k) % 32] > 0) w.a = 5'((s + k) % 32);
               end
            end
            if (w.a != 5'd0 || $urandom_range(0, 3) == 0) push_req(who, w.a, w.d);
         end
      end
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
   endtask

   // Monitor: every cycle the write port must match the oldest accepted nonzero-address write
   initial begin
      wr_t w;
      bit  ev;
      forever begin
         @(negedge clk);
         if (rst === 1'b0) begin
            ev = (exp_q.size() != 0);
            chk("rf_wen", {31'd0, rf_wen}, {31'd0, ev});
            if (ev) begin
               w = exp_q.pop_front();
               if (rf_wen === 1'b1) begin
                  chk("wr_addr", {27'd0, wr_addr}, {27'd0, w.a});
                  chk("wd", wd, w.d);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      {iss_valid, req0_valid, req1_valid} = '0;
      iss_rd = '0; req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
      rs1_addr = 5'd5; rs2_addr = 5'd0;
      model_reset();
      #1;
      chk("reset rf_wen", {31'd0, rf_wen}, 32'd0);
      chk("reset wr_addr", {27'd0, wr_addr}, 32'd0);
      chk("reset wd", wd, 32'd0);
      chk("reset iss_ready", {31'd0, iss_ready}, 32'd1);
      chk("reset rs1_busy", {31'd0, rs1_busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // single write to r5
      step(1'b1, 5'd5, 5'd5, 5'd0);
      push_req(0, 5'd5, 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 5'd5, 5'd5);

      // contention: ALU 1,2,3 against LSU 9,10,11
      step(1'b1, 5'd1, 5'd0, 5'd0);
      step(1'b1, 5'd2, 5'd0, 5'd0);
      step(1'b1, 5'd3, 5'd0, 5'd0);
      step(1'b1, 5'd9, 5'd0, 5'd0);
      step(1'b1, 5'd10, 5'd0, 5'd0);
      step(1'b1, 5'd11, 5'd0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         push_req(0, 5'(i + 1), $urandom);
         push_req(1, 5'(i + 9), $urandom);
      end
      for (int i = 0; i < 8; i++) step(1'b0, 5'd0, 5'(i + 1), 5'(i + 8));

      // x0 write is consumed without a port write
      push_req(1, 5'd0, 32'h12345678);
      step(1'b0, 5'd0, 5'd0, 5'd0);
      step(1'b0, 5'd0, 5'd0, 5'd0);
      step(1'b1, 5'd0, 5'd0, 5'd0);

      // saturation on r7, release by commit, overlapping issue and commit
      for (int i = 0; i < 4; i++) step(1'b1, 5'd7, 5'd7, 5'd0);
      push_req(0, 5'd7, $urandom);
      for (int i = 0; i < 3; i++) step(1'b1, 5'd7, 5'd7, 5'd0);
      push_req(0, 5'd7, $urandom);
      for (int i = 0; i < 3; i++) step(1'b1, 5'd7, 5'd7, 5'd0);
      for (int i = 0; i < 3; i++) begin
         push_req(1, 5'd7, $urandom);
         step(1'b0, 5'd0, 5'd7, 5'd0);
         step(1'b0, 5'd0, 5'd7, 5'd0);
      end

      // forwarding window on r4
      step(1'b1, 5'd4, 5'd0, 5'd4);
      push_req(0, 5'd4, 32'hA5A5A5A5);
      step(1'b0, 5'd0, 5'd0, 5'd4);
      step(1'b0, 5'd0, 5'd4, 5'd4);
      step(1'b0, 5'd0, 5'd4, 5'd4);

      for (int i = 0; i < 300; i++) rand_step();

      // reset mid-stream with a request pending and a write on the port
      step(1'b1, 5'd6, 5'd0, 5'd0);
      push_req(0, 5'd6, $urandom);
      step(1'b0, 5'd0, 5'd0, 5'd0);
      push_req(0, 5'd0, $urandom);
      req0_valid = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      chk("mid reset rf_wen", {31'd0, rf_wen}, 32'd0);
      chk("mid reset wr_addr", {27'd0, wr_addr}, 32'd0);
      chk("mid reset wd", wd, 32'd0);
      model_reset();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      iss_valid  = 1'b0;
      for (int a = 0; a < 32; a++) begin
         rs1_addr = 5'(a);
         #1;
         chk("reset rs1_busy", {31'd0, rs1_busy}, 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 5'd6, 5'd7);
      for (int i = 0; i < 200; i++) rand_step();
      for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 5'd0, 5'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
